// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: datapath width, opcodes, NOP encoding and the
// memory-access-unit state encodings used by the multicycle core.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Memory access unit FSM encodings (kept as plain constants so older
    // blocks that compare raw state bits keep working).
    localparam logic [1:0] MAU_IDLE = 2'd0;
    localparam logic [1:0] MAU_REQ  = 2'd1;
    localparam logic [1:0] MAU_WAIT = 2'd2;
    localparam logic [1:0] MAU_DONE = 2'd3;

    // Kind of access latched when a transaction starts.
    typedef enum logic [1:0] {
        ACC_FETCH = 2'd0,
        ACC_LOAD  = 2'd1,
        ACC_STORE = 2'd2
    } acc_kind_e;

    // Word accesses only: the two address LSBs must be zero.
    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Memory access unit for the multicycle core. Converts the control FSM's
// fetch/load/store strobes into one req/gnt/rvalid transaction on the unified
// memory port, owns IR / OldPC / Data registers and stalls control until the
// access has finished.
module mem_access_unit #(
    parameter int          XLEN           = 32,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] RESET_INSTR    = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ir_write,
    input  logic            mem_write,
    input  logic            instruction_or_data,
    input  logic            pc_write,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] data_addr,
    input  logic [XLEN-1:0] write_data,
    output logic            pc_write_en,
    output logic            stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] old_pc,
    output logic [XLEN-1:0] data_reg,
    output logic            misaligned,
    output logic            bus_error
);

    import riscv_pkg::*;

    // Counter only needs to reach TIMEOUT_CYCLES-1; width 1 when disabled.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]       state;
    acc_kind_e        kind;
    logic [CNT_W-1:0] tmo_cnt;

    logic             fetch_req, store_req, load_req, any_req;
    logic [XLEN-1:0]  req_addr;
    logic             busy, resp_ok, tmo_hit;

    // Fetch has priority; a store issued together with a fetch is dropped.
    assign fetch_req = ir_write;
    assign store_req = mem_write & ~ir_write;
    assign load_req  = instruction_or_data & ~mem_write & ~ir_write;
    assign any_req   = fetch_req | store_req | load_req;
    assign req_addr  = instruction_or_data ? data_addr : pc;

    assign busy    = (state == MAU_REQ) || (state == MAU_WAIT);
    // Response accepted: rvalid with gnt in REQ, or rvalid alone in WAIT.
    assign resp_ok = ((state == MAU_REQ) && mem_gnt && mem_rvalid) ||
                     ((state == MAU_WAIT) && mem_rvalid);
    // A response arriving on the last allowed cycle still wins over timeout.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && busy && (tmo_cnt == TMO_LAST) && !resp_ok;

    // Stall is combinational in IDLE so control holds from the very first cycle.
    assign stall       = any_req & (state != MAU_DONE);
    assign pc_write_en = pc_write & ~stall;
    assign mem_req     = (state == MAU_REQ);

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Transaction FSM: latch the request in IDLE, hold it through REQ, collect
    // the response in WAIT, and give control one non-stalled cycle in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= MAU_IDLE;
            kind       <= ACC_FETCH;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            case (state)
                MAU_IDLE: begin
                    if (any_req) begin
                        mem_addr  <= req_addr;
                        mem_we    <= store_req;
                        mem_wdata <= write_data;
                        kind      <= fetch_req ? ACC_FETCH :
                                     (store_req ? ACC_STORE : ACC_LOAD);
                        if (word_aligned(req_addr[1:0])) begin
                            state <= MAU_REQ;
                        end else begin
                            state      <= MAU_DONE;
                            misaligned <= 1'b1;
                        end
                    end
                end
                MAU_REQ, MAU_WAIT: begin
                    if (resp_ok) begin
                        state <= MAU_DONE;
                    end else if (tmo_hit) begin
                        state     <= MAU_DONE;
                        bus_error <= 1'b1;
                    end else if ((state == MAU_REQ) && mem_gnt) begin
                        state <= MAU_WAIT;
                    end
                end
                default: state <= MAU_IDLE;
            endcase
        end
    end

    // Timeout counter: cleared whenever idle, counts every REQ/WAIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (busy) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Result registers: IR/OldPC on a fetch response, Data on a load response.
    // old_pc takes pc here, before control bumps it in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr    <= RESET_INSTR;
            old_pc   <= '0;
            data_reg <= '0;
        end else if (resp_ok) begin
            if (kind == ACC_FETCH) begin
                instr  <= mem_rdata;
                old_pc <= pc;
            end else if (kind == ACC_LOAD) begin
                data_reg <= mem_rdata;
            end
        end
    end

endmodule
